he_rst_seq: RTL and testbench
=============================

HE_RST_SEQ -- requirements
Module: he_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of sequenced reset channels, legal 1..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: clkin cycles all channels stay asserted after reset entry, legal >=1.
REQ-003 SHALL have parameter STAGE_GAP, default 2: clkin cycles between successive channel releases, legal >=1.
REQ-004 SHALL have parameter DIV, default 2: clk_en period in clkin cycles, legal >=1.
REQ-005 SHALL have port clkin  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port rstin  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sw_rst_req  input  1  synchronous soft-reset request, active-high, level-sampled.
REQ-008 SHALL have port rstout  output  NUM_CH  per-channel reset, active-low, registered.
REQ-009 SHALL have port rst_done  output  1  high once every channel is released, registered.
REQ-010 SHALL have port clk_en  output  1  divided clock-enable pulse, registered.

Function
REQ-011 SHALL assert-synchronise rstin through a 2-flop synchroniser (both stages cleared asynchronously by rstin low, shifting in 1 while rstin high); rstin deassertion SHALL never reach the FSM in fewer than 2 edges.
REQ-012 SHALL implement the FSM states RESET, HOLD, RELEASE, RUN.
REQ-013 SHALL have RESET as the state whenever rstin is low; the FSM SHALL go RESET->HOLD on the edge where the second synchroniser stage captures 1 (edge 2, counting edge 1 as the first rising clkin with rstin high).
REQ-014 SHALL stay in HOLD for HOLD_CYCLES edges with its hold counter cleared on entry, then go HOLD->RELEASE on edge E+HOLD_CYCLES, where E is the HOLD entry edge.
REQ-015 SHALL drive rstout[0] high after edge E+HOLD_CYCLES and rstout[k] high after edge E+HOLD_CYCLES+k*STAGE_GAP; a released channel SHALL stay high until the next reset entry.
REQ-016 SHALL go RELEASE->RUN one edge after rstout[NUM_CH-1] rises, with rst_done rising on that same edge.
REQ-017 SHALL, with NUM_CH=1, go to RUN one edge after rstout[0] rises.
REQ-018 SHALL, when sw_rst_req is sampled high on edge N in HOLD, RELEASE or RUN, drive all rstout low and rst_done low after edge N and re-enter HOLD with E=N.
REQ-019 SHALL, while sw_rst_req stays high, keep the hold counter cleared and all channels asserted; release timing SHALL count from the last edge where sw_rst_req was sampled high.
REQ-020 SHALL ignore sw_rst_req in RESET; rstin low SHALL take priority over sw_rst_req.
REQ-021 SHALL size the hold, stage-gap and channel-index counters with $clog2 of their maximum count (minimum 1 bit); the counters SHALL never wrap within a sequence.
REQ-022 SHALL keep the divider counter at 0 while rst_done is low; from the first cycle rst_done is high, clk_en SHALL be high for one cycle every DIV cycles, starting in that first cycle.
REQ-023 SHALL hold clk_en constantly high while rst_done is high when DIV=1.
REQ-024 SHALL drive clk_en low in the same cycle rst_done falls, whether from soft or hard reset.
REQ-025 SHALL generate an elaboration-time error for any parameter outside its legal range.

Reset
REQ-026 SHALL, on rstin low, asynchronously force all rstout=0, rst_done=0, clk_en=0, the synchroniser to 0, the FSM to RESET and all counters to 0, regardless of clkin.
REQ-027 SHALL, on rstin assertion mid-sequence (HOLD or RELEASE), abort the sequence immediately, and the next release SHALL restart from REQ-013.

Verification
REQ-028 SHALL cover power-on with defaults, rstin released before edge 1: rstout[0] rises after edge 6, [1] after 8, [2] after 10, [3] after 12; rst_done after 13; clk_en high in cycles 13, 15, 17.
REQ-029 SHALL cover a 1-cycle sw_rst_req pulse at edge 20 in RUN (defaults): all rstout=0 and rst_done=0 after edge 20; rstout[0] rises after 24, rstout[3] after 30, rst_done after 31.
REQ-030 SHALL cover sw_rst_req held high for edges 20..25: all channels stay low; rstout[0] rises after 29.
REQ-031 SHALL cover rstin pulsed low between edges 9 and 10 (mid-RELEASE): rstout immediately 0 with no clock; the sequence restarts per REQ-013 from the first edge after release.
REQ-032 SHALL cover NUM_CH=1, HOLD_CYCLES=1, DIV=1: rstout[0] rises after edge 3, rst_done and constant clk_en follow after edge 4.
REQ-033 SHALL cover sw_rst_req high throughout RESET: it is ignored, and timing is identical to REQ-028 once sw_rst_req goes low before edge 2.

Source files
------------

// File: rtl/he_rst_seq.sv
// Sequenced reset controller: synchronises rstin, holds all channels in reset,
// releases them one by one, then reports done and runs a divided clock-enable.
module he_rst_seq #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_GAP   = 2,
    parameter int DIV         = 2
) (
    input  logic              clkin,
    input  logic              rstin,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rstout,
    output logic              rst_done,
    output logic              clk_en
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("he_rst_seq: NUM_CH must be 1..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("he_rst_seq: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("he_rst_seq: STAGE_GAP must be >= 1");
    end
    if (DIV < 1) begin : g_bad_div
        $error("he_rst_seq: DIV must be >= 1");
    end

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_HOLD    = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        sync_q;
    logic [HOLD_W-1:0] hold_q;
    logic [GAP_W-1:0]  gap_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DIV_W-1:0]  div_q;
    logic [NUM_CH-1:0] rstout_q;
    logic              done_q;
    logic              en_q;

    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            state_q  <= S_RESET;
            sync_q   <= '0;
            hold_q   <= '0;
            gap_q    <= '0;
            idx_q    <= '0;
            div_q    <= '0;
            rstout_q <= '0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
            // Leave RESET on the same edge the second stage captures 1.
            if (state_q == S_RESET) begin
                if (sync_q[0]) begin
                    state_q <= S_HOLD;
                    hold_q  <= '0;
                end
            end else if (sw_rst_req) begin
                state_q  <= S_HOLD;
                hold_q   <= '0;
                gap_q    <= '0;
                idx_q    <= '0;
                div_q    <= '0;
                rstout_q <= '0;
                done_q   <= 1'b0;
                en_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_HOLD: begin
                        if (sync_q[1] && hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                            state_q  <= S_RELEASE;
                            rstout_q <= NUM_CH'(1);
                            idx_q    <= '0;
                            gap_q    <= '0;
                        end else if (sync_q[1]) begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        // idx_q is the highest channel already released.
                        if (idx_q == IDX_W'(NUM_CH - 1)) begin
                            state_q <= S_RUN;
                            done_q  <= 1'b1;
                            en_q    <= 1'b1;
                            div_q   <= (DIV == 1) ? '0 : DIV_W'(1);
                        end else if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
                            rstout_q <= (rstout_q << 1) | NUM_CH'(1);
                            idx_q    <= idx_q + 1'b1;
                            gap_q    <= '0;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    S_RUN: begin
                        en_q  <= (div_q == '0);
                        div_q <= (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rstout   = rstout_q;
    assign rst_done = done_q;
    assign clk_en   = en_q;

endmodule

// File: tb/tb_he_rst_seq.sv
// Directed bench for he_rst_seq: a default instance and a NUM_CH=1/HOLD=1/DIV=1
// instance share clock, rstin and sw_rst_req; outputs checked against tables.
module tb_he_rst_seq;

    logic       clk = 1'b0;
    logic       rstin = 1'b0;
    logic       sw = 1'b0;
    logic [3:0] a_out;
    logic       a_done, a_en;
    logic [0:0] b_out;
    logic       b_done, b_en;
    logic [8:0] act;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    he_rst_seq u_a (
        .clkin(clk), .rstin(rstin), .sw_rst_req(sw),
        .rstout(a_out), .rst_done(a_done), .clk_en(a_en)
    );

    he_rst_seq #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGE_GAP(2), .DIV(1)) u_b (
        .clkin(clk), .rstin(rstin), .sw_rst_req(sw),
        .rstout(b_out), .rst_done(b_done), .clk_en(b_en)
    );

    assign act = {a_out, a_done, a_en, b_out, b_done, b_en};

    typedef struct {
        int         en_n;
        logic       sw;
        logic [8:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int n, logic s, logic [3:0] ao, logic ad, logic ae,
                                logic bo, logic bd, logic be);
        vec_t v;
        v.en_n = n;
        v.sw   = s;
        v.exp  = {ao, ad, ae, bo, bd, be};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [8:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s edge %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic step_to(input int n, input logic s);
        while (cyc < n) begin
            sw = s;
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic start_seq(input logic sw0);
        @(negedge clk);
        rstin = 1'b0;
        sw    = sw0;
        #1;
        chk("async_reset", 9'b0);
        @(negedge clk);
        rstin = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_table(input string nm);
        start_seq(vq[0].sw);
        foreach (vq[i]) begin
            step_to(vq[i].en_n, vq[i].sw);
            chk(nm, vq[i].exp);
        end
    endtask

    initial begin
        // power-on with a 1-cycle soft reset pulse at edge 20
        vq = {};
        vq.push_back(mk( 1, 0, 4'b0000, 0, 0, 0, 0, 0));
        vq.push_back(mk( 2, 0, 4'b0000, 0, 0, 0, 0, 0));
        vq.push_back(mk( 3, 0, 4'b0000, 0, 0, 1, 0, 0));
        vq.push_back(mk( 4, 0, 4'b0000, 0, 0, 1, 1, 1));
        vq.push_back(mk( 5, 0, 4'b0000, 0, 0, 1, 1, 1));
        vq.push_back(mk( 6, 0, 4'b0001, 0, 0, 1, 1, 1));
        vq.push_back(mk( 7, 0, 4'b0001, 0, 0, 1, 1, 1));
        vq.push_back(mk( 8, 0, 4'b0011, 0, 0, 1, 1, 1));
        vq.push_back(mk(10, 0, 4'b0111, 0, 0, 1, 1, 1));
        vq.push_back(mk(12, 0, 4'b1111, 0, 0, 1, 1, 1));
        vq.push_back(mk(13, 0, 4'b1111, 1, 1, 1, 1, 1));
        vq.push_back(mk(14, 0, 4'b1111, 1, 0, 1, 1, 1));
        vq.push_back(mk(15, 0, 4'b1111, 1, 1, 1, 1, 1));
        vq.push_back(mk(17, 0, 4'b1111, 1, 1, 1, 1, 1));
        vq.push_back(mk(19, 0, 4'b1111, 1, 1, 1, 1, 1));
        vq.push_back(mk(20, 1, 4'b0000, 0, 0, 0, 0, 0));
        vq.push_back(mk(21, 0, 4'b0000, 0, 0, 1, 0, 0));
        vq.push_back(mk(22, 0, 4'b0000, 0, 0, 1, 1, 1));
        vq.push_back(mk(23, 0, 4'b0000, 0, 0, 1, 1, 1));
        vq.push_back(mk(24, 0, 4'b0001, 0, 0, 1, 1, 1));
        vq.push_back(mk(29, 0, 4'b0111, 0, 0, 1, 1, 1));
        vq.push_back(mk(30, 0, 4'b1111, 0, 0, 1, 1, 1));
        vq.push_back(mk(31, 0, 4'b1111, 1, 1, 1, 1, 1));
        vq.push_back(mk(32, 0, 4'b1111, 1, 0, 1, 1, 1));
        run_table("pulse_seq");

        // soft reset held over edges 20..25
        vq = {};
        vq.push_back(mk(13, 0, 4'b1111, 1, 1, 1, 1, 1));
        vq.push_back(mk(19, 0, 4'b1111, 1, 1, 1, 1, 1));
        vq.push_back(mk(25, 1, 4'b0000, 0, 0, 0, 0, 0));
        vq.push_back(mk(28, 0, 4'b0000, 0, 0, 1, 1, 1));
        vq.push_back(mk(29, 0, 4'b0001, 0, 0, 1, 1, 1));
        vq.push_back(mk(35, 0, 4'b1111, 0, 0, 1, 1, 1));
        vq.push_back(mk(36, 0, 4'b1111, 1, 1, 1, 1, 1));
        run_table("held_sw");

        // soft reset high during RESET and edge 1 is ignored
        vq = {};
        vq.push_back(mk( 1, 1, 4'b0000, 0, 0, 0, 0, 0));
        vq.push_back(mk( 5, 0, 4'b0000, 0, 0, 1, 1, 1));
        vq.push_back(mk( 6, 0, 4'b0001, 0, 0, 1, 1, 1));
        vq.push_back(mk(13, 0, 4'b1111, 1, 1, 1, 1, 1));
        vq.push_back(mk(14, 0, 4'b1111, 1, 0, 1, 1, 1));
        run_table("sw_in_reset");

        // rstin pulsed low between edges 9 and 10, mid-release
        start_seq(1'b0);
        step_to(9, 1'b0);
        chk("pre_abort", {4'b0011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        #1;
        rstin = 1'b0;
        #1;
        chk("abort_no_clk", 9'b0);
        @(negedge clk);
        rstin = 1'b1;
        cyc   = 0;
        step_to(2, 1'b0);
        chk("restart_e2", 9'b0);
        step_to(5, 1'b0);
        chk("restart_e5", {4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        step_to(6, 1'b0);
        chk("restart_e6", {4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        step_to(13, 1'b0);
        chk("restart_e13", {4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
